// File: rtl/id_ex_forward.sv
// rtl/id_ex_forward.sv - ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding
module id_ex_forward #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [2:0]        id_ULAcontrole,
  input  logic              id_ULASrc,
  input  logic              id_RegDst,
  input  logic              id_RegWrite,
  input  logic              id_MemtoReg,
  input  logic              id_MemWrite,
  input  logic              mem_RegWrite,
  input  logic [REG_AW-1:0] mem_WriteReg,
  input  logic [DATA_W-1:0] mem_ULAresult,
  input  logic              wb_RegWrite,
  input  logic [REG_AW-1:0] wb_WriteReg,
  input  logic [DATA_W-1:0] wb_Result,
  output logic [2:0]        ULAcontrole,
  output logic [DATA_W-1:0] SrcA,
  output logic [DATA_W-1:0] SrcB,
  output logic [DATA_W-1:0] ex_WriteData,
  output logic [REG_AW-1:0] ex_WriteReg,
  output logic              ex_valid,
  output logic              ex_RegWrite,
  output logic              ex_MemtoReg,
  output logic              ex_MemWrite,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [1:0]        fwdA,
  output logic [1:0]        fwdB
);

  logic              r_valid;
  logic [2:0]        r_ULAcontrole;
  logic              r_ULASrc;
  logic              r_RegDst;
  logic              r_RegWrite;
  logic              r_MemtoReg;
  logic              r_MemWrite;
  logic [REG_AW-1:0] r_rs;
  logic [REG_AW-1:0] r_rt;
  logic [REG_AW-1:0] r_rd;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_imm;

  logic [1:0]        w_fwdA;
  logic [1:0]        w_fwdB;
  logic [DATA_W-1:0] w_a_fwd;
  logic [DATA_W-1:0] w_b_fwd;

  // MEM wins over WB; register 0 is hard-wired and never forwarded
  always_comb begin
    w_fwdA = 2'b00;
    if (mem_RegWrite && (mem_WriteReg != '0) && (mem_WriteReg == r_rs))
      w_fwdA = 2'b10;
    else if (wb_RegWrite && (wb_WriteReg != '0) && (wb_WriteReg == r_rs))
      w_fwdA = 2'b01;

    w_fwdB = 2'b00;
    if (mem_RegWrite && (mem_WriteReg != '0) && (mem_WriteReg == r_rt))
      w_fwdB = 2'b10;
    else if (wb_RegWrite && (wb_WriteReg != '0) && (wb_WriteReg == r_rt))
      w_fwdB = 2'b01;
  end

  always_comb begin
    case (w_fwdA)
      2'b10:   w_a_fwd = mem_ULAresult;
      2'b01:   w_a_fwd = wb_Result;
      default: w_a_fwd = r_a;
    endcase
    case (w_fwdB)
      2'b10:   w_b_fwd = mem_ULAresult;
      2'b01:   w_b_fwd = wb_Result;
      default: w_b_fwd = r_b;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_valid       <= 1'b0;
      r_ULAcontrole <= 3'b000;
      r_ULASrc      <= 1'b0;
      r_RegDst      <= 1'b0;
      r_RegWrite    <= 1'b0;
      r_MemtoReg    <= 1'b0;
      r_MemWrite    <= 1'b0;
      r_rs          <= '0;
      r_rt          <= '0;
      r_rd          <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_imm         <= '0;
    end else if (stall) begin
      // Capture forwarded operands so a producer retiring from WB mid-stall is kept
      r_a <= w_a_fwd;
      r_b <= w_b_fwd;
    end else begin
      r_valid       <= id_valid;
      r_ULAcontrole <= id_ULAcontrole;
      r_ULASrc      <= id_ULASrc;
      r_RegDst      <= id_RegDst;
      r_RegWrite    <= id_RegWrite;
      r_MemtoReg    <= id_MemtoReg;
      r_MemWrite    <= id_MemWrite;
      r_rs          <= id_rs;
      r_rt          <= id_rt;
      r_rd          <= id_rd;
      r_a           <= id_rd1;
      r_b           <= id_rd2;
      r_imm         <= id_imm;
    end
  end

  assign ULAcontrole  = r_ULAcontrole;
  assign SrcA         = w_a_fwd;
  assign SrcB         = r_ULASrc ? r_imm : w_b_fwd;
  assign ex_WriteData = w_b_fwd;
  assign ex_WriteReg  = r_RegDst ? r_rd : r_rt;
  assign ex_valid     = r_valid;
  assign ex_RegWrite  = r_RegWrite;
  assign ex_MemtoReg  = r_MemtoReg;
  assign ex_MemWrite  = r_MemWrite;
  assign ex_rs        = r_rs;
  assign ex_rt        = r_rt;
  assign fwdA         = w_fwdA;
  assign fwdB         = w_fwdB;

endmodule

// File: doc/id_ex_forward.md
Name: id_ex_forward

Overview:
- ID/EX pipeline register and operand-forwarding stage of the pipelined MIPS core.
- Sits directly upstream of the 32-bit ULA and drives its ULAcontrole, SrcA and SrcB inputs.
- Latches decoded operands and control from ID, and resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages.
- Supports stall (hold) and flush (bubble) requests from the hazard unit.

Parameters:
DATA_W, 32, datapath width; must match the ULA width.
REG_AW, 5, register-address width.

Ports:
clk  in  1  clock, rising-edge.
reset  in  1  synchronous, active-high reset.
stall  in  1  hold the ID/EX contents this cycle.
flush  in  1  load a bubble this cycle.
id_valid  in  1  the ID slot holds a real instruction.
id_rd1, id_rd2  in  DATA_W  register-file read data for rs and rt.
id_imm  in  DATA_W  sign-extended immediate.
id_rs, id_rt, id_rd  in  REG_AW  source and destination register fields.
id_ULAcontrole  in  3  ULA operation code.
id_ULASrc, id_RegDst, id_RegWrite, id_MemtoReg, id_MemWrite  in  1 each  decoded control bits.
mem_RegWrite  in  1  the EX/MEM instruction writes a register.
mem_WriteReg  in  REG_AW  EX/MEM destination register.
mem_ULAresult  in  DATA_W  EX/MEM ULA result.
wb_RegWrite  in  1  the MEM/WB instruction writes a register.
wb_WriteReg  in  REG_AW  MEM/WB destination register.
wb_Result  in  DATA_W  MEM/WB write-back value.
ULAcontrole  out  3  to the ULA.
SrcA, SrcB  out  DATA_W  to the ULA.
ex_WriteData  out  DATA_W  forwarded rt value, used as store data.
ex_WriteReg  out  REG_AW  ex_RegDst ? ex_rd : ex_rt.
ex_valid, ex_RegWrite, ex_MemtoReg, ex_MemWrite  out  1 each  registered control.
ex_rs, ex_rt  out  REG_AW  registered fields for the hazard unit.
fwdA, fwdB  out  2  forwarding selects: 00 = register, 10 = MEM, 01 = WB.

Behaviour:
- Single clock domain, clk. Reset is synchronous and active-high, sampled on the rising edge of clk.
- Update priority on each rising edge: reset > flush > stall > normal load.
- Reset and flush:
  - All registered fields go to 0: valid, all control bits, ULAcontrole, rs, rt, rd, operand registers, immediate.
  - Consequences: ULAcontrole=000, SrcA=0, SrcB=0, ex_WriteReg=0, fwdA=fwdB=00.
- Normal load: all id_* inputs are captured. Latency is 1 cycle from ID inputs to outputs.
- Stall:
  - Control, rs, rt, rd, immediate and ULAcontrole hold their values.
  - The operand registers re-latch the current forwarded A and B values, so a producer leaving WB during the stall is not lost.
  - After the stall ends, the re-latched values are used with fwd=00 unless a new match exists.
- Forwarding is combinational on the registered ex_rs and ex_rt:
  - fwdA=10 if mem_RegWrite, mem_WriteReg!=0 and mem_WriteReg==ex_rs.
  - Otherwise fwdA=01 if wb_RegWrite, wb_WriteReg!=0 and wb_WriteReg==ex_rs.
  - Otherwise fwdA=00.
  - fwdB is the same, using ex_rt.
  - MEM has priority over WB when both match.
  - Register 0 is never forwarded.
- Operand muxes:
  - SrcA is the forwarded A value.
  - ex_WriteData is the forwarded B value.
  - SrcB = ex_ULASrc ? imm_q : forwarded B value.
- Forwarding is not gated by ex_valid. A bubble carries rs=rt=0, so it never forwards.
- No X propagation: every output is driven from reset onward.
- No arithmetic is performed; widths pass through unchanged.

Test Plan:
- Reset plus load:
  - Stimulus: assert reset for 2 cycles, then load id_rd1=5, id_rd2=7, ULAcontrole=010, ULASrc=0, rs=1, rt=2, no forwarding.
  - Response: during reset all outputs are 0. One cycle after the load, SrcA=5, SrcB=7, fwdA=fwdB=00.
- MEM forwarding with priority over WB:
  - Stimulus: ex_rs=3; mem_RegWrite=1, mem_WriteReg=3, mem_ULAresult=0xAAAA0000; wb_RegWrite=1, wb_WriteReg=3, wb_Result=0x1234.
  - Response: fwdA=10, SrcA=0xAAAA0000. When the MEM match is removed: fwdA=01, SrcA=0x1234.
- Register-0 suppression and immediate select:
  - Stimulus: ex_rt=0, mem_WriteReg=0, mem_RegWrite=1, id_rd2=9, then ULASrc=1 with imm=0xFFFFFFFC.
  - Response: fwdB=00, ex_WriteData=9, SrcB=0xFFFFFFFC.
- Stall re-latch:
  - Stimulus: ex_rs=4 with WB forwarding 0x55; assert stall for 1 cycle while WB retires; next cycle wb_RegWrite=0.
  - Response: SrcA stays 0x55 and fwdA=00 after the stall.
- Flush beats stall:
  - Stimulus: stall=1 and flush=1 together with a valid instruction in EX.
  - Response: next cycle ex_valid=0, ex_RegWrite=0, ex_MemWrite=0, ULAcontrole=000, SrcA=SrcB=0.
- RegDst select:
  - Stimulus: rt=8, rd=12; RegDst=1, then RegDst=0.
  - Response: ex_WriteReg=12, then 8.
